// File: rtl/count_pkg.sv
// ----------------------------------------------------------------------------
// count_pkg
//   Shared definitions for count_sequencer and its prescaler.
//   Provides the 2-bit run/pause/clear FSM state type and the state encodings.
// ----------------------------------------------------------------------------
package count_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_PAUSE = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/count_sequencer_tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
//   DIV_MAX prescaler for count_sequencer. The prescaler counts
//   0..DIV_MAX-1 while en is high and holds while en is low. The zero input
//   forces the count back to 0.
//
//   Ports
//     clk    in   system clock
//     reset  in   asynchronous, active-high reset
//     en     in   advance the prescaler this cycle
//     zero   in   synchronously return the prescaler to 0 (wins over en)
//     tick   out  combinational strobe: high when en is set and the count
//                 sits at DIV_MAX-1. The parent registers the visible tick
//                 and the counter step on the same edge.
// ----------------------------------------------------------------------------
module tick_gen #(
   parameter int DIV_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic zero,
   output logic tick
);

   localparam int PW = $clog2(DIV_MAX);
   localparam logic [PW-1:0] LAST = PW'(DIV_MAX - 1);

   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;

   always_comb begin
      pre_d = pre_q;
      if (zero) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign tick = en && (pre_q == LAST);

endmodule

// File: rtl/count_sequencer.sv
// ----------------------------------------------------------------------------
// count_sequencer
//   Run/pause/clear controller for the 1 Hz binary up/down counter.
//   Single-cycle button pulses drive an IDLE/RUN/PAUSE/DONE FSM. The FSM
//   gates a prescaler, and each prescaler tick steps a CNT_W-bit counter
//   toward its terminal value: CNT_MAX when counting up, 0 when counting down.
//
//   Build option: define AUTO_RELOAD_EN to wrap the counter at the terminal
//   value and stay in RUN, with done as a one-cycle pulse. When it is left
//   undefined, the counter holds at the terminal value, the FSM parks in
//   DONE, and done is a level.
//
//   Ports
//     clk         in   system clock
//     reset       in   asynchronous, active-high reset
//     start_stop  in   pulse: IDLE->RUN, RUN<->PAUSE (ignored in DONE)
//     clear       in   pulse: counter to 0, FSM to IDLE (highest priority)
//     load        in   pulse: counter <= load_val in IDLE/PAUSE only
//     load_val    in   value to load, saturated to CNT_MAX
//     dir         in   0 = count up, 1 = count down (sampled on each tick)
//     cnt_out     out  counter value
//     tick        out  one-cycle prescaler pulse, coincident with the step
//     running     out  high while in RUN
//     done        out  terminal indication
//     state_dbg   out  current FSM state, for observation
//   All outputs are registered.
// ----------------------------------------------------------------------------
module count_sequencer
   import count_pkg::*;
#(
   parameter int DIV_MAX = 50_000_000,
   parameter int CNT_W   = 4,
   parameter int CNT_MAX = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_stop,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dir,
   output logic [CNT_W-1:0] cnt_out,
   output logic             tick,
   output logic             running,
   output logic             done,
   output state_t           state_dbg
);

   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             running_q, running_d;
   logic             done_q, done_d;

   logic             load_ok;
   logic             ss_ok;
   logic             pre_en;
   logic             pre_zero;
   logic             fire;
   logic [CNT_W-1:0] term_v;
   logic             at_term;
   logic [CNT_W-1:0] load_sat;

   // Event arbitration: clear > load > start_stop > tick.
   // A load that is taken consumes a coincident start_stop.
   assign load_ok  = load && !clear && (state_q == ST_IDLE || state_q == ST_PAUSE);
   assign ss_ok    = start_stop && !clear && !load_ok;

   // The prescaler only advances on cycles where the FSM stays in RUN. A
   // pause therefore freezes the exact phase, and a resume continues from it.
   assign pre_en   = (state_q == ST_RUN) && !clear && !ss_ok;
   assign pre_zero = clear || (state_q == ST_IDLE && ss_ok);

   assign term_v   = dir ? '0 : MAX_V;
   assign at_term  = (cnt_q == term_v);
   assign load_sat = (load_val > MAX_V) ? MAX_V : load_val;

   tick_gen #(
      .DIV_MAX (DIV_MAX)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .en    (pre_en),
      .zero  (pre_zero),
      .tick  (fire)
   );

   // State register, including the registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else if (ss_ok) begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = state_q;
         endcase
      end else if (fire && at_term) begin
`ifdef AUTO_RELOAD_EN
         state_d = ST_RUN;
`else
         state_d = ST_DONE;
`endif
      end
   end

   // Output and datapath logic. fire is already gated off by clear and by a
   // taken start_stop, so a coincident clear never produces a step or done.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (load_ok) begin
         cnt_d = load_sat;
      end else if (fire) begin
         if (!at_term) begin
            cnt_d = dir ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
         end else begin
`ifdef AUTO_RELOAD_EN
            cnt_d = dir ? MAX_V : '0;
`else
            cnt_d = cnt_q;
`endif
         end
      end

      tick_d    = fire;
      running_d = (state_d == ST_RUN);
`ifdef AUTO_RELOAD_EN
      done_d    = fire && at_term;
`else
      done_d    = (state_d == ST_DONE);
`endif
   end

   assign cnt_out   = cnt_q;
   assign tick      = tick_q;
   assign running   = running_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// ----------------------------------------------------------------------------
// tb_count_sequencer
//   Directed bench for count_sequencer with DIV_MAX=4, CNT_W=4, CNT_MAX=15.
//   A second instance with CNT_W=5 exercises load saturation for values that
//   a 4-bit port cannot carry. Inputs change 1 ns after a rising edge.
//   Outputs are sampled at the same point, and each sample reflects that edge.
// ----------------------------------------------------------------------------
module tb_count_sequencer;
   import count_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic       dir = 1'b0;
   logic [3:0] cnt_out;
   logic       tick, running, done;
   state_t     state_dbg;

   logic       load_w = 1'b0;
   logic [4:0] load_val_w = '0;
   logic [4:0] cnt_w;
   logic       tick_w, running_w, done_w;
   state_t     state_w;

   int vec_cnt = 0;
   int err_cnt = 0;

   count_sequencer #(.DIV_MAX(4), .CNT_W(4), .CNT_MAX(15)) dut (
      .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
      .load(load), .load_val(load_val), .dir(dir), .cnt_out(cnt_out),
      .tick(tick), .running(running), .done(done), .state_dbg(state_dbg)
   );

   count_sequencer #(.DIV_MAX(4), .CNT_W(5), .CNT_MAX(15)) dut_w (
      .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
      .load(load_w), .load_val(load_val_w), .dir(dir), .cnt_out(cnt_w),
      .tick(tick_w), .running(running_w), .done(done_w), .state_dbg(state_w)
   );

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      step(1);
      start_stop = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      step(3);
      vec_cnt++;
      if (cnt_out !== 4'd0 || tick !== 1'b0 || running !== 1'b0 || done !== 1'b0 || state_dbg !== ST_IDLE) begin
         err_cnt++;
         $display("FAIL reset_hold: cnt=%0d tick=%b run=%b done=%b st=%0d, want 0 0 0 0 0", cnt_out, tick, running, done, state_dbg);
      end
      reset = 1'b0;
      step(2);
      vec_cnt++;
      if (cnt_out !== 4'd0 || running !== 1'b0 || state_dbg !== ST_IDLE) begin
         err_cnt++;
         $display("FAIL reset_release: cnt=%0d run=%b st=%0d, want 0 0 0", cnt_out, running, state_dbg);
      end
   endtask

   task automatic test_load_sat();
      load_w = 1'b1; load_val_w = 5'd20;
      step(1);
      load_w = 1'b0;
      vec_cnt++;
      if (cnt_w !== 5'd15 || state_w !== ST_IDLE || running_w !== 1'b0 || done_w !== 1'b0 || tick_w !== 1'b0) begin
         err_cnt++;
         $display("FAIL load_sat_20: cnt=%0d st=%0d run=%b done=%b tick=%b, want 15 0 0 0 0", cnt_w, state_w, running_w, done_w, tick_w);
      end
      load_w = 1'b1; load_val_w = 5'd9;
      step(1);
      load_w = 1'b0;
      vec_cnt++;
      if (cnt_w !== 5'd9) begin
         err_cnt++;
         $display("FAIL load_w_9: cnt=%0d, want 9", cnt_w);
      end
      load_w = 1'b1; load_val_w = 5'd16;
      step(1);
      load_w = 1'b0;
      vec_cnt++;
      if (cnt_w !== 5'd15) begin
         err_cnt++;
         $display("FAIL load_sat_16: cnt=%0d, want 15", cnt_w);
      end
      pulse_clear();
   endtask

   task automatic test_count_up();
      dir = 1'b0;
      pulse_ss();
      vec_cnt++;
      if (running !== 1'b1 || state_dbg !== ST_RUN || cnt_out !== 4'd0 || tick !== 1'b0) begin
         err_cnt++;
         $display("FAIL up_start: run=%b st=%0d cnt=%0d tick=%b, want 1 1 0 0", running, state_dbg, cnt_out, tick);
      end
      for (int k = 1; k <= 3; k++) begin
         step(3);
         vec_cnt++;
         if (tick !== 1'b0 || cnt_out !== 4'(k - 1)) begin
            err_cnt++;
            $display("FAIL up_between: tick=%b cnt=%0d, want 0 %0d", tick, cnt_out, k - 1);
         end
         step(1);
         vec_cnt++;
         if (tick !== 1'b1 || cnt_out !== 4'(k) || running !== 1'b1) begin
            err_cnt++;
            $display("FAIL up_tick: tick=%b cnt=%0d run=%b, want 1 %0d 1", tick, cnt_out, running, k);
         end
      end
   endtask

   task automatic test_pause_resume();
      logic bad;
      step(8);
      vec_cnt++;
      if (cnt_out !== 4'd5 || tick !== 1'b1) begin
         err_cnt++;
         $display("FAIL pause_reach5: cnt=%0d tick=%b, want 5 1", cnt_out, tick);
      end
      step(2);
      pulse_ss();
      vec_cnt++;
      if (state_dbg !== ST_PAUSE || running !== 1'b0 || cnt_out !== 4'd5) begin
         err_cnt++;
         $display("FAIL pause_enter: st=%0d run=%b cnt=%0d, want 2 0 5", state_dbg, running, cnt_out);
      end
      bad = 1'b0;
      repeat (20) begin
         step(1);
         if (cnt_out !== 4'd5 || tick !== 1'b0 || state_dbg !== ST_PAUSE) bad = 1'b1;
      end
      vec_cnt++;
      if (bad !== 1'b0) begin
         err_cnt++;
         $display("FAIL pause_hold: moved=%b, want 0", bad);
      end
      pulse_ss();
      vec_cnt++;
      if (running !== 1'b1 || cnt_out !== 4'd5 || tick !== 1'b0) begin
         err_cnt++;
         $display("FAIL resume_edge: run=%b cnt=%0d tick=%b, want 1 5 0", running, cnt_out, tick);
      end
      step(1);
      vec_cnt++;
      if (cnt_out !== 4'd5 || tick !== 1'b0) begin
         err_cnt++;
         $display("FAIL resume_plus1: cnt=%0d tick=%b, want 5 0", cnt_out, tick);
      end
      step(1);
      vec_cnt++;
      if (cnt_out !== 4'd6 || tick !== 1'b1) begin
         err_cnt++;
         $display("FAIL resume_plus2: cnt=%0d tick=%b, want 6 1", cnt_out, tick);
      end
   endtask

   task automatic test_terminal_up();
      logic bad;
      for (int v = 7; v <= 15; v++) begin
         step(4);
         vec_cnt++;
         if (cnt_out !== 4'(v) || tick !== 1'b1) begin
            err_cnt++;
            $display("FAIL term_climb: cnt=%0d tick=%b, want %0d 1", cnt_out, tick, v);
         end
      end
      step(4);
`ifdef AUTO_RELOAD_EN
      vec_cnt++;
      if (cnt_out !== 4'd0 || done !== 1'b1 || running !== 1'b1 || tick !== 1'b1) begin
         err_cnt++;
         $display("FAIL wrap_up: cnt=%0d done=%b run=%b tick=%b, want 0 1 1 1", cnt_out, done, running, tick);
      end
      step(1);
      vec_cnt++;
      if (done !== 1'b0 || running !== 1'b1 || state_dbg !== ST_RUN) begin
         err_cnt++;
         $display("FAIL wrap_done_pulse: done=%b run=%b st=%0d, want 0 1 1", done, running, state_dbg);
      end
`else
      vec_cnt++;
      if (cnt_out !== 4'd15 || done !== 1'b1 || state_dbg !== ST_DONE || running !== 1'b0) begin
         err_cnt++;
         $display("FAIL done_up: cnt=%0d done=%b st=%0d run=%b, want 15 1 3 0", cnt_out, done, state_dbg, running);
      end
      pulse_ss();
      bad = 1'b0;
      repeat (8) begin
         step(1);
         if (state_dbg !== ST_DONE || cnt_out !== 4'd15 || done !== 1'b1 || tick !== 1'b0) bad = 1'b1;
      end
      vec_cnt++;
      if (bad !== 1'b0) begin
         err_cnt++;
         $display("FAIL done_ignores_ss: moved=%b, want 0", bad);
      end
`endif
      pulse_clear();
      vec_cnt++;
      if (cnt_out !== 4'd0 || done !== 1'b0 || state_dbg !== ST_IDLE || running !== 1'b0) begin
         err_cnt++;
         $display("FAIL clear_after_term: cnt=%0d done=%b st=%0d run=%b, want 0 0 0 0", cnt_out, done, state_dbg, running);
      end
   endtask

   task automatic test_load_down();
      pulse_ss();
      pulse_ss();
      vec_cnt++;
      if (state_dbg !== ST_PAUSE || cnt_out !== 4'd0) begin
         err_cnt++;
         $display("FAIL ld_pause: st=%0d cnt=%0d, want 2 0", state_dbg, cnt_out);
      end
      load = 1'b1; load_val = 4'd9;
      step(1);
      load = 1'b0;
      vec_cnt++;
      if (cnt_out !== 4'd9 || state_dbg !== ST_PAUSE) begin
         err_cnt++;
         $display("FAIL ld_9: cnt=%0d st=%0d, want 9 2", cnt_out, state_dbg);
      end
      dir = 1'b1;
      pulse_ss();
      load = 1'b1; load_val = 4'd3;
      step(1);
      load = 1'b0;
      vec_cnt++;
      if (cnt_out !== 4'd9 || running !== 1'b1) begin
         err_cnt++;
         $display("FAIL ld_ignored_run: cnt=%0d run=%b, want 9 1", cnt_out, running);
      end
      step(3);
      vec_cnt++;
      if (cnt_out !== 4'd8 || tick !== 1'b1) begin
         err_cnt++;
         $display("FAIL down_first: cnt=%0d tick=%b, want 8 1", cnt_out, tick);
      end
      for (int v = 7; v >= 0; v--) begin
         step(4);
         vec_cnt++;
         if (cnt_out !== 4'(v) || tick !== 1'b1) begin
            err_cnt++;
            $display("FAIL down_step: cnt=%0d tick=%b, want %0d 1", cnt_out, tick, v);
         end
      end
      step(4);
`ifdef AUTO_RELOAD_EN
      vec_cnt++;
      if (cnt_out !== 4'd15 || done !== 1'b1 || running !== 1'b1) begin
         err_cnt++;
         $display("FAIL wrap_down: cnt=%0d done=%b run=%b, want 15 1 1", cnt_out, done, running);
      end
`else
      vec_cnt++;
      if (cnt_out !== 4'd0 || done !== 1'b1 || state_dbg !== ST_DONE) begin
         err_cnt++;
         $display("FAIL done_down: cnt=%0d done=%b st=%0d, want 0 1 3", cnt_out, done, state_dbg);
      end
`endif
      pulse_clear();
      dir = 1'b0;
   endtask

   task automatic test_priority();
      pulse_ss();
      step(8);
      vec_cnt++;
      if (cnt_out !== 4'd2 || tick !== 1'b1) begin
         err_cnt++;
         $display("FAIL prio_setup: cnt=%0d tick=%b, want 2 1", cnt_out, tick);
      end
      step(3);
      // The prescaler is now at its last count; the next edge would tick.
      clear = 1'b1; load = 1'b1; load_val = 4'd7;
      step(1);
      clear = 1'b0; load = 1'b0;
      vec_cnt++;
      if (cnt_out !== 4'd0 || state_dbg !== ST_IDLE || done !== 1'b0 || tick !== 1'b0 || running !== 1'b0) begin
         err_cnt++;
         $display("FAIL clear_load_tick: cnt=%0d st=%0d done=%b tick=%b run=%b, want 0 0 0 0 0", cnt_out, state_dbg, done, tick, running);
      end
      load = 1'b1; start_stop = 1'b1; load_val = 4'd4;
      step(1);
      load = 1'b0; start_stop = 1'b0;
      vec_cnt++;
      if (cnt_out !== 4'd4 || state_dbg !== ST_IDLE) begin
         err_cnt++;
         $display("FAIL load_over_ss: cnt=%0d st=%0d, want 4 0", cnt_out, state_dbg);
      end
   endtask

   task automatic test_reset_mid_run();
      pulse_ss();
      step(6);
      vec_cnt++;
      if (cnt_out !== 4'd5 || running !== 1'b1) begin
         err_cnt++;
         $display("FAIL rst_setup: cnt=%0d run=%b, want 5 1", cnt_out, running);
      end
      reset = 1'b1;
      #1;
      vec_cnt++;
      if (cnt_out !== 4'd0 || running !== 1'b0 || tick !== 1'b0 || done !== 1'b0 || state_dbg !== ST_IDLE) begin
         err_cnt++;
         $display("FAIL rst_async: cnt=%0d run=%b tick=%b done=%b st=%0d, want 0 0 0 0 0", cnt_out, running, tick, done, state_dbg);
      end
      step(2);
      reset = 1'b0;
      step(6);
      vec_cnt++;
      if (cnt_out !== 4'd0 || running !== 1'b0 || state_dbg !== ST_IDLE) begin
         err_cnt++;
         $display("FAIL rst_after: cnt=%0d run=%b st=%0d, want 0 0 0", cnt_out, running, state_dbg);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_load_sat();
      test_count_up();
      test_pause_resume();
      test_terminal_up();
      test_load_down();
      test_priority();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: sequence still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
